// File: rtl/logic_axi4_lite_bus_multi_master_pkg.sv
// Shared types for the AXI4-Lite bus: path FSM states and grant-index sizing.
package logic_axi4_lite_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDRESS, RESPONSE} state_t;

  // Grant index width; a single requester still gets a 1-bit index.
  function automatic int gidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_axi4_lite_bus_multi_master_if.sv
// AXI4-Lite channel bundle. "master" drives requests, "slave" drives ready/responses.
interface logic_axi4_lite_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
);
  logic                       awvalid, awready;
  logic [ADDRESS_WIDTH-1:0]   awaddr;
  logic [2:0]                 awprot;
  logic                       wvalid, wready;
  logic [8*DATA_BYTES-1:0]    wdata;
  logic [DATA_BYTES-1:0]      wstrb;
  logic                       bvalid, bready;
  logic [1:0]                 bresp;
  logic                       arvalid, arready;
  logic [ADDRESS_WIDTH-1:0]   araddr;
  logic [2:0]                 arprot;
  logic                       rvalid, rready;
  logic [8*DATA_BYTES-1:0]    rdata;
  logic [1:0]                 rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/logic_axi4_lite_bus_multi_master_arbiter.sv
// Request arbiter for one bus path: picks a winner among MASTERS requesters and
// registers it while load is high. Fixed priority (lowest index) by default;
// LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN selects round-robin with a pointer.
module logic_axi4_lite_bus_arbiter
  import logic_axi4_lite_bus_pkg::*;
#(
  parameter  int MASTERS = 2,
  localparam int IW      = gidx_w(MASTERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MASTERS-1:0] req,
  input  logic               load,
  output logic [IW-1:0]      grant,
  output logic               grant_valid
);

  logic [IW-1:0] win;
  logic          found;

  assign grant_valid = |req;

`ifdef LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN
  localparam logic [IW:0] COUNT = (IW+1)'(MASTERS);
  logic [IW-1:0] ptr;
  logic [IW:0]   idx;

  // rotating search: first requester at or after the pointer
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MASTERS; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= COUNT) idx = idx - COUNT;
      for (int j = 0; j < MASTERS; j++)
        if (!found && req[j] && idx == (IW+1)'(j)) begin
          win   = IW'(j);
          found = 1'b1;
        end
    end
  end

  // pointer moves one past the winner on every grant
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (load && grant_valid)
      ptr <= (win == IW'(MASTERS-1)) ? '0 : win + IW'(1);
  end
`else
  // fixed priority: lowest requesting index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < MASTERS; j++)
      if (!found && req[j]) begin
        win   = IW'(j);
        found = 1'b1;
      end
  end
`endif

  // grant is captured only while the owning FSM is idle, so it holds for the transaction
  always_ff @(posedge clk) begin
    if (!rst_n)
      grant <= '0;
    else if (load && grant_valid)
      grant <= win;
  end

endmodule

// File: rtl/logic_axi4_lite_bus_multi_master.sv
// Multi-master AXI4-Lite arbiter: MASTERS upstream managers share one downstream
// port. Write and read paths arbitrate independently, one outstanding each.
// Optional macro: LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN (round-robin grants).
module logic_axi4_lite_bus_multi_master
  import logic_axi4_lite_bus_pkg::*;
#(
  parameter int MASTERS       = 2,
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
) (
  input  logic               aclk,
  input  logic               areset_n,
  logic_axi4_lite_if.slave   slave [MASTERS],
  logic_axi4_lite_if.master  master
);

  localparam int IW = gidx_w(MASTERS);
  localparam int DW = 8 * DATA_BYTES;

  logic [MASTERS-1:0]                    s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0] s_awaddr, s_araddr;
  logic [MASTERS-1:0][2:0]               s_awprot, s_arprot;
  logic [MASTERS-1:0][DW-1:0]            s_wdata;
  logic [MASTERS-1:0][DATA_BYTES-1:0]    s_wstrb;

  state_t        wr_state, wr_next, rd_state, rd_next;
  logic [IW-1:0] wr_grant, rd_grant;
  logic          wr_any, rd_any;
  logic          aw_done, w_done;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = master.awvalid & master.awready;
  assign w_hs  = master.wvalid  & master.wready;
  assign b_hs  = master.bvalid  & master.bready;
  assign ar_hs = master.arvalid & master.arready;
  assign r_hs  = master.rvalid  & master.rready;

  logic_axi4_lite_bus_arbiter #(.MASTERS(MASTERS)) u_wr_arb (
    .clk(aclk), .rst_n(areset_n), .req(s_awvalid), .load(wr_state == IDLE),
    .grant(wr_grant), .grant_valid(wr_any)
  );

  logic_axi4_lite_bus_arbiter #(.MASTERS(MASTERS)) u_rd_arb (
    .clk(aclk), .rst_n(areset_n), .req(s_arvalid), .load(rd_state == IDLE),
    .grant(rd_grant), .grant_valid(rd_any)
  );

  // write state plus sticky AW/W completion flags, cleared whenever ADDRESS is left
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wr_state <= IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (wr_next != ADDRESS) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // write next state: AW and W may finish in either order or together
  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      IDLE:     if (wr_any) wr_next = ADDRESS;
      ADDRESS:  if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = RESPONSE;
      RESPONSE: if (b_hs) wr_next = IDLE;
      default:  wr_next = IDLE;
    endcase
  end

  // write outputs: forward valids of the granted master, masked once accepted
  always_comb begin
    master.awvalid = 1'b0;
    master.wvalid  = 1'b0;
    master.bready  = 1'b0;
    if (wr_state == ADDRESS) begin
      master.awvalid = !aw_done && s_awvalid[wr_grant];
      master.wvalid  = !w_done  && s_wvalid[wr_grant];
    end
    if (wr_state == RESPONSE)
      master.bready = s_bready[wr_grant];
  end

  // read state register
  always_ff @(posedge aclk) begin
    if (!areset_n) rd_state <= IDLE;
    else           rd_state <= rd_next;
  end

  // read next state
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      IDLE:     if (rd_any) rd_next = ADDRESS;
      ADDRESS:  if (ar_hs) rd_next = RESPONSE;
      RESPONSE: if (r_hs) rd_next = IDLE;
      default:  rd_next = IDLE;
    endcase
  end

  // read outputs
  always_comb begin
    master.arvalid = 1'b0;
    master.rready  = 1'b0;
    if (rd_state == ADDRESS)  master.arvalid = s_arvalid[rd_grant];
    if (rd_state == RESPONSE) master.rready  = s_rready[rd_grant];
  end

  assign master.awaddr = s_awaddr[wr_grant];
  assign master.awprot = s_awprot[wr_grant];
  assign master.wdata  = s_wdata[wr_grant];
  assign master.wstrb  = s_wstrb[wr_grant];
  assign master.araddr = s_araddr[rd_grant];
  assign master.arprot = s_arprot[rd_grant];

  // per-upstream flattening and response steering; only the grantee sees ready/valid
  for (genvar i = 0; i < MASTERS; i++) begin : g_up
    logic wsel, rsel;
    assign wsel = (wr_grant == IW'(i));
    assign rsel = (rd_grant == IW'(i));

    assign s_awvalid[i] = slave[i].awvalid;
    assign s_awaddr[i]  = slave[i].awaddr;
    assign s_awprot[i]  = slave[i].awprot;
    assign s_wvalid[i]  = slave[i].wvalid;
    assign s_wdata[i]   = slave[i].wdata;
    assign s_wstrb[i]   = slave[i].wstrb;
    assign s_bready[i]  = slave[i].bready;
    assign s_arvalid[i] = slave[i].arvalid;
    assign s_araddr[i]  = slave[i].araddr;
    assign s_arprot[i]  = slave[i].arprot;
    assign s_rready[i]  = slave[i].rready;

    assign slave[i].awready = wsel && (wr_state == ADDRESS) && !aw_done && master.awready;
    assign slave[i].wready  = wsel && (wr_state == ADDRESS) && !w_done  && master.wready;
    assign slave[i].bvalid  = wsel && (wr_state == RESPONSE) && master.bvalid;
    assign slave[i].bresp   = master.bresp;
    assign slave[i].arready = rsel && (rd_state == ADDRESS) && master.arready;
    assign slave[i].rvalid  = rsel && (rd_state == RESPONSE) && master.rvalid;
    assign slave[i].rdata   = master.rdata;
    assign slave[i].rresp   = master.rresp;
  end

endmodule

// File: tb/tb_logic_axi4_lite_bus_multi_master.sv
// Directed bench for logic_axi4_lite_bus_multi_master, MASTERS=2.
// Expectations follow LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN when defined.
module tb_logic_axi4_lite_bus_multi_master;
  import logic_axi4_lite_bus_pkg::*;

  localparam int M  = 2;
  localparam int DB = 4;
  localparam int AW = 8;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic_axi4_lite_if #(.DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) s_if [M] ();
  logic_axi4_lite_if #(.DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) m_if ();

  logic_axi4_lite_bus_multi_master #(.MASTERS(M), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) dut (
    .aclk(aclk), .areset_n(areset_n), .slave(s_if), .master(m_if)
  );

  // upstream drive / observe
  logic [M-1:0]          awv, wv, bry, arv, rry;
  logic [M-1:0][AW-1:0]  awaddr, araddr;
  logic [M-1:0][2:0]     awprot, arprot;
  logic [M-1:0][31:0]    wdata;
  logic [M-1:0][3:0]     wstrb;
  logic [M-1:0]          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [M-1:0][1:0]     s_bresp, s_rresp;
  logic [M-1:0][31:0]    s_rdata;

  for (genvar i = 0; i < M; i++) begin : g_s
    assign s_if[i].awvalid = awv[i];
    assign s_if[i].awaddr  = awaddr[i];
    assign s_if[i].awprot  = awprot[i];
    assign s_if[i].wvalid  = wv[i];
    assign s_if[i].wdata   = wdata[i];
    assign s_if[i].wstrb   = wstrb[i];
    assign s_if[i].bready  = bry[i];
    assign s_if[i].arvalid = arv[i];
    assign s_if[i].araddr  = araddr[i];
    assign s_if[i].arprot  = arprot[i];
    assign s_if[i].rready  = rry[i];
    assign s_awready[i] = s_if[i].awready;
    assign s_wready[i]  = s_if[i].wready;
    assign s_bvalid[i]  = s_if[i].bvalid;
    assign s_bresp[i]   = s_if[i].bresp;
    assign s_arready[i] = s_if[i].arready;
    assign s_rvalid[i]  = s_if[i].rvalid;
    assign s_rdata[i]   = s_if[i].rdata;
    assign s_rresp[i]   = s_if[i].rresp;
  end

  // downstream slave stub
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  assign m_if.awready = m_awready;
  assign m_if.wready  = m_wready;
  assign m_if.bvalid  = m_bvalid;
  assign m_if.bresp   = m_bresp;
  assign m_if.arready = m_arready;
  assign m_if.rvalid  = m_rvalid;
  assign m_if.rdata   = m_rdata;
  assign m_if.rresp   = m_rresp;

  // downstream handshake counters
  int aw_cnt = 0;
  int w_cnt  = 0;
  always @(posedge aclk)
    if (areset_n) begin
      if (m_if.awvalid && m_if.awready) aw_cnt <= aw_cnt + 1;
      if (m_if.wvalid && m_if.wready)   w_cnt  <= w_cnt + 1;
    end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  int aw0, w0;
  logic [7:0] order;
  logic [1:0] exp_g;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    awv = '0; wv = '0; bry = '0; arv = '0; rry = '0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;

    // reset state
    tick(); tick();
    chk("rst_awvalid", 64'(m_if.awvalid), 0);
    chk("rst_wvalid",  64'(m_if.wvalid), 0);
    chk("rst_arvalid", 64'(m_if.arvalid), 0);
    chk("rst_bready",  64'(m_if.bready), 0);
    chk("rst_rready",  64'(m_if.rready), 0);
    chk("rst_up_rdy",  64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 0);
    areset_n = 1;

    // slave[1] writes 0xA5A5A5A5 to 0x4
    m_awready = 1; m_wready = 1;
    awv = 2'b10; awaddr[1] = 8'h04; awprot[1] = 3'b010;
    wv  = 2'b10; wdata[1] = 32'hA5A5A5A5; wstrb[1] = 4'hF;
    #1 chk("t1_idle_awvalid", 64'(m_if.awvalid), 0);
    tick();
    chk("t1_awvalid", 64'(m_if.awvalid), 1);
    chk("t1_awaddr",  64'(m_if.awaddr), 64'h04);
    chk("t1_awprot",  64'(m_if.awprot), 64'h2);
    chk("t1_wvalid",  64'(m_if.wvalid), 1);
    chk("t1_wdata",   64'(m_if.wdata), 64'hA5A5A5A5);
    chk("t1_wstrb",   64'(m_if.wstrb), 64'hF);
    chk("t1_s_awready", 64'(s_awready), 64'b10);
    chk("t1_s_wready",  64'(s_wready), 64'b10);
    tick();
    awv = '0; wv = '0; m_bvalid = 1; m_bresp = 2'b00; bry = 2'b11;
    #1 chk("t1_s_bvalid", 64'(s_bvalid), 64'b10);
    chk("t1_bresp", 64'(s_bresp[1]), 0);
    chk("t1_bready", 64'(m_if.bready), 1);
    chk("t1_state_resp", 64'(dut.wr_state), 64'(RESPONSE));
    tick();
    m_bvalid = 0;
    #1 chk("t1_s_bvalid_off", 64'(s_bvalid), 0);
    chk("t1_state_idle", 64'(dut.wr_state), 64'(IDLE));

    // simultaneous requests, four back-to-back transactions
`ifdef LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN
    order = 8'b10_01_10_01;
`else
    order = 8'b01_01_01_01;
`endif
    awv = 2'b11; wv = 2'b11; bry = 2'b11; m_bvalid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = order[2*i +: 2];
      chk($sformatf("t2_grant%0d", i), 64'(s_awready), 64'(exp_g));
      tick(); tick();
    end
    awv = '0; wv = '0; bry = '0; m_bvalid = 0;

    // W leads AW by two cycles, then AW and W together
    aw0 = aw_cnt; w0 = w_cnt;
    m_awready = 0; m_wready = 1;
    wv = 2'b01; wdata[0] = 32'h11111111; wstrb[0] = 4'hF;
    tick(); tick();
    chk("t3_wait_idle", 64'(dut.wr_state), 64'(IDLE));
    chk("t3_wait_wready", 64'(s_wready), 0);
    awv = 2'b01; awaddr[0] = 8'h20;
    tick();
    chk("t3_fwd_wvalid", 64'(m_if.wvalid), 1);
    chk("t3_fwd_awvalid", 64'(m_if.awvalid), 1);
    tick();
    chk("t3_w_masked", 64'(m_if.wvalid), 0);
    chk("t3_s_wready_masked", 64'(s_wready), 0);
    tick();
    chk("t3_still_addr", 64'(dut.wr_state), 64'(ADDRESS));
    chk("t3_aw_pending", 64'(m_if.awvalid), 1);
    m_awready = 1;
    tick();
    awv = '0; wv = '0;
    #1 chk("t3_resp", 64'(dut.wr_state), 64'(RESPONSE));
    chk("t3_aw_count", 64'(aw_cnt - aw0), 1);
    chk("t3_w_count",  64'(w_cnt - w0), 1);
    m_bvalid = 1; bry = 2'b01;
    tick();
    m_bvalid = 0; bry = '0;
    aw0 = aw_cnt; w0 = w_cnt;
    awv = 2'b01; wv = 2'b01;
    tick(); tick();
    awv = '0; wv = '0;
    #1 chk("t3b_resp", 64'(dut.wr_state), 64'(RESPONSE));
    chk("t3b_aw_count", 64'(aw_cnt - aw0), 1);
    chk("t3b_w_count",  64'(w_cnt - w0), 1);
    m_bvalid = 1; bry = 2'b01;
    tick();
    m_bvalid = 0; bry = '0;

    // read by slave[1] while slave[0] write waits for B
    awv = 2'b01; wv = 2'b01;
    tick(); tick();
    awv = '0; wv = '0;
    arv = 2'b10; araddr[1] = 8'h08; m_arready = 1;
    #1 chk("t4_ar_idle", 64'(m_if.arvalid), 0);
    tick();
    chk("t4_arvalid", 64'(m_if.arvalid), 1);
    chk("t4_araddr",  64'(m_if.araddr), 64'h08);
    chk("t4_s_arready", 64'(s_arready), 64'b10);
    tick();
    arv = '0; m_rvalid = 1; m_rdata = 32'h12345678; m_rresp = 2'b10; rry = 2'b10;
    #1 chk("t4_s_rvalid", 64'(s_rvalid), 64'b10);
    chk("t4_rdata", 64'(s_rdata[1]), 64'h12345678);
    chk("t4_rresp", 64'(s_rresp[1]), 64'h2);
    chk("t4_rready", 64'(m_if.rready), 1);
    chk("t4_wr_pending", 64'(dut.wr_state), 64'(RESPONSE));
    tick();
    m_rvalid = 0; rry = '0;
    #1 chk("t4_rd_idle", 64'(dut.rd_state), 64'(IDLE));
    chk("t4_s_rvalid_off", 64'(s_rvalid), 0);

    // bready held low: B stays pending, new request waits
    m_bvalid = 1; bry = 2'b00; m_awready = 0; m_wready = 0;
    awv = 2'b10; wv = 2'b10; awaddr[1] = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_bvalid%0d", i), 64'(s_bvalid), 64'b01);
      chk($sformatf("t5_bready%0d", i), 64'(m_if.bready), 0);
      chk($sformatf("t5_noaw%0d", i), 64'(m_if.awvalid), 0);
      chk($sformatf("t5_state%0d", i), 64'(dut.wr_state), 64'(RESPONSE));
    end
    bry = 2'b01;
    #1 chk("t5_bready_on", 64'(m_if.bready), 1);
    tick();
    m_bvalid = 0;
    #1 chk("t5_idle", 64'(dut.wr_state), 64'(IDLE));
    tick();
    chk("t5_new_awvalid", 64'(m_if.awvalid), 1);
    chk("t5_new_awaddr",  64'(m_if.awaddr), 64'h10);

    // reset in ADDRESS
    areset_n = 0;
    tick();
    chk("t6_awvalid", 64'(m_if.awvalid), 0);
    chk("t6_wvalid",  64'(m_if.wvalid), 0);
    chk("t6_up", 64'({s_awready, s_wready, s_bvalid}), 0);
    chk("t6_state", 64'(dut.wr_state), 64'(IDLE));
    areset_n = 1;
    awv = 2'b01; wv = '0;
    tick();
    chk("t6_regrant", 64'(m_if.awaddr), 64'h20);
`ifdef LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN
    chk("t6_ptr_set", 64'(dut.u_wr_arb.ptr), 1);
`endif
    areset_n = 0;
    tick();
    chk("t6b_awvalid", 64'(m_if.awvalid), 0);
    chk("t6b_state", 64'(dut.wr_state), 64'(IDLE));
`ifdef LOGIC_AXI4_LITE_BUS_MULTI_MASTER_ROUND_ROBIN_EN
    chk("t6b_ptr", 64'(dut.u_wr_arb.ptr), 0);
`endif
    awv = '0;
    areset_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
